ext_msg_ram_mb: RTL and testbench

Multi-bank extrinsic-message store for the layered LDPC decoder.
- Parallel successor to the single-port extrinsic RAM: NUM_BANKS independent banks, each with one synchronous read port and one write port per cycle.
- Adds a built-in clear sequencer that zeroes every entry after reset and on request, before each new codeword.
- Sits between the check-node processing lanes and the message arithmetic; one bank per lane.

---
 rtl/ext_msg_ram_mb_pkg.sv | 24 ++
 rtl/ext_msg_ram_mb_bank.sv | 74 +++++++
 rtl/ext_msg_ram_mb.sv | 165 ++++++++++++++++
 tb/tb_ext_msg_ram_mb.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_msg_ram_mb_pkg.sv
// ---------------------------------------------------------------------------
// ext_ram_pkg
// Shared definitions for the multi-bank extrinsic-message store.
//   ram_state_e : sequencer states (IDLE, CLEAR, READY)
//   lane_lsb()  : LSB position of lane 'lane' inside a packed multi-lane bus
//                 whose lanes are 'width' bits wide.
// No optional features live here; EXT_RAM_BYPASS_EN is handled in the bank.
// ---------------------------------------------------------------------------
package ext_ram_pkg;

  // Sequencer states. IDLE is only seen between reset release and the
  // first clock edge; CLEAR is the zeroing sweep; READY accepts traffic.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    READY = 2'd2
  } ram_state_e;

  // Lanes are packed little-end first: lane k occupies [k*width +: width].
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/ext_msg_ram_mb_bank.sv
// ---------------------------------------------------------------------------
// ext_bank_1r1w
// One simple dual-port synchronous bank: one write port and one registered
// read port, both usable every cycle. Contents are not reset; only the read
// register is, so rd_data starts at zero.
//
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset (read register only)
//   wr_en    : write enable
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : load the read register this cycle
//   rd_addr  : read address
//   rd_data  : registered read data, held when rd_en is low
//
// Build option:
//   EXT_RAM_BYPASS_EN : when defined, a read and write to the same address in
//                       the same cycle return the new write data. When not
//                       defined the read returns the old contents and no
//                       forwarding logic exists.
// ---------------------------------------------------------------------------
module ext_bank_1r1w
  import ext_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_next;

  // Storage array: written at the edge, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Value the read register will capture. The array read happens before the
  // same-edge write, so without forwarding a collision yields old contents.
`ifdef EXT_RAM_BYPASS_EN
  always_comb begin
    rd_next = mem[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_next = wr_data;
    end
  end
`else
  always_comb begin
    rd_next = mem[rd_addr];
  end
`endif

  // Registered read port; holds its value between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_next;
    end
  end

endmodule

// File: rtl/ext_msg_ram_mb.sv
// ---------------------------------------------------------------------------
// ext_msg_ram_mb
// Multi-bank extrinsic-message store for the layered LDPC decoder. One bank
// per check-node lane, each with a synchronous read port and a write port.
// A built-in sequencer zeroes every entry after reset (when CLR_ON_RESET=1)
// and whenever clr_req is pulsed, so each codeword starts from clean state.
//
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   clr_req  : single-cycle pulse, zero all banks
//   busy     : clear sweep in progress
//   ready    : memory initialised and accepting traffic
//   rd_en    : read all banks this cycle
//   rd_addr  : per-lane read address, lane k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data  : per-lane read data, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rd_valid : rd_data updated this cycle (one cycle after an accepted read)
//   wr_en    : per-lane write enable
//   wr_addr  : per-lane write address
//   wr_data  : per-lane write data
//
// Build option:
//   EXT_RAM_BYPASS_EN : write-first forwarding on same-lane, same-address
//                       read/write collisions (implemented inside each bank).
// ---------------------------------------------------------------------------
module ext_msg_ram_mb
  import ext_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 5,
  parameter int ADDR_WIDTH   = 8,
  parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
  parameter int NUM_BANKS    = 4,
  parameter int CLR_ON_RESET = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clr_req,
  output logic                            busy,
  output logic                            ready,
  input  logic                            rd_en,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data,
  output logic                            rd_valid,
  input  logic [NUM_BANKS-1:0]            wr_en,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] wr_data
);

  // One extra counter bit keeps the terminal compare meaningful even when
  // RAM_DEPTH fills the whole address space.
  localparam int                   CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(RAM_DEPTH - 1);

  ram_state_e           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 user_rd;
  logic                 user_wr_ok;
  logic                 clearing;

  // User traffic is only honoured in READY. A clear request landing in READY
  // still lets that cycle's read complete but drops its writes, so nothing
  // written alongside the request survives into the new codeword.
  assign clearing   = (state == CLEAR);
  assign user_rd    = (state == READY) && rd_en;
  assign user_wr_ok = (state == READY) && !clr_req;

  // Sequencer: state, sweep counter and the registered status outputs.
  // busy/ready are registered alongside the state so they change on the same
  // edge as the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= user_rd;
      case (state)
        IDLE: begin
          // A request in IDLE simply acts as the automatic start.
          if ((CLR_ON_RESET != 0) || clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
            ready <= 1'b0;
          end else begin
            state <= READY;
            busy  <= 1'b0;
            ready <= 1'b1;
          end
        end
        CLEAR: begin
          // A new request restarts the sweep from the first address; it
          // takes priority over finishing the current sweep.
          if (clr_req) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= READY;
            cnt   <= '0;
            busy  <= 1'b0;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READY: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // One bank per lane. The write port of each bank is shared between the
  // clear sweep (zero at cnt) and the user lane write.
  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    localparam int A_LSB = lane_lsb(k, ADDR_WIDTH);
    localparam int D_LSB = lane_lsb(k, DATA_WIDTH);

    logic                  bank_we;
    logic [ADDR_WIDTH-1:0] bank_waddr;
    logic [DATA_WIDTH-1:0] bank_wdata;

    // Write-port mux: the sweep owns the port while clearing.
    always_comb begin
      bank_we    = 1'b0;
      bank_waddr = wr_addr[A_LSB +: ADDR_WIDTH];
      bank_wdata = wr_data[D_LSB +: DATA_WIDTH];
      if (clearing) begin
        bank_we    = 1'b1;
        bank_waddr = cnt[ADDR_WIDTH-1:0];
        bank_wdata = '0;
      end else if (user_wr_ok) begin
        bank_we = wr_en[k];
      end
    end

    ext_bank_1r1w #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .RAM_DEPTH  (RAM_DEPTH)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (bank_we),
      .wr_addr (bank_waddr),
      .wr_data (bank_wdata),
      .rd_en   (user_rd),
      .rd_addr (rd_addr[A_LSB +: ADDR_WIDTH]),
      .rd_data (rd_data[D_LSB +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_ext_msg_ram_mb.sv
// ---------------------------------------------------------------------------
// tb_ext_msg_ram_mb
// Scoreboard bench for ext_msg_ram_mb (4 lanes, 5-bit data, 16 entries).
// The reference keeps a plain per-lane array of the expected contents; every
// accepted read pushes its expected lane data into a queue, and a monitor
// pops and compares whenever the design raises rd_valid. Clear sweeps are
// timed against the expected length and the memory model is zeroed when a
// sweep completes. Honours EXT_RAM_BYPASS_EN for collision results.
// ---------------------------------------------------------------------------
module tb_ext_msg_ram_mb;

  localparam int NB    = 4;
  localparam int DW    = 5;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clr_req = 1'b0;
  logic             busy;
  logic             ready;
  logic             rd_en = 1'b0;
  logic [NB*AW-1:0] rd_addr = '0;
  logic [NB*DW-1:0] rd_data;
  logic             rd_valid;
  logic [NB-1:0]    wr_en = '0;
  logic [NB*AW-1:0] wr_addr = '0;
  logic [NB*DW-1:0] wr_data = '0;

  int checks = 0;
  int errors = 0;

  // Reference state: expected contents per lane, pending read results, and
  // whether the bench believes the memory is accepting traffic.
  logic [DW-1:0]    ref_mem [NB][DEPTH];
  logic [NB*DW-1:0] exp_q [$];
  logic [NB*DW-1:0] last_exp = '0;
  logic             m_ready = 1'b0;

  ext_msg_ram_mb #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .RAM_DEPTH    (DEPTH),
    .NUM_BANKS    (NB),
    .CLR_ON_RESET (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .busy     (busy),
    .ready    (ready),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  // Global watchdog so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rd_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rd_valid: got rd_data %0h with no read outstanding", rd_data);
      end else begin
        check_output("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Drive one cycle of inputs, update the reference model, then advance to
  // just after the edge that samples them.
  task automatic apply_stimulus(input logic rd, input logic [NB*AW-1:0] ra,
                                input logic [NB-1:0] we, input logic [NB*AW-1:0] wa,
                                input logic [NB*DW-1:0] wd, input logic clr);
    logic [NB*DW-1:0] exp;
    logic [AW-1:0]    a;
    rd_en   = rd;
    rd_addr = ra;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    clr_req = clr;
    if (m_ready) begin
      if (rd) begin
        exp = '0;
        for (int k = 0; k < NB; k++) begin
          a = ra[k*AW +: AW];
          exp[k*DW +: DW] = ref_mem[k][a];
`ifdef EXT_RAM_BYPASS_EN
          if (we[k] && !clr && (wa[k*AW +: AW] == a)) begin
            exp[k*DW +: DW] = wd[k*DW +: DW];
          end
`endif
        end
        exp_q.push_back(exp);
        last_exp = exp;
      end
      if (!clr) begin
        for (int k = 0; k < NB; k++) begin
          if (we[k]) begin
            ref_mem[k][wa[k*AW +: AW]] = wd[k*DW +: DW];
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, '0, '0, '0, '0, 1'b0);
  endtask

  // One cycle of random traffic; write addresses often alias read addresses
  // so that same-cycle collisions are exercised.
  task automatic random_cycle(input logic clr);
    logic [NB*AW-1:0] ra;
    logic [NB*AW-1:0] wa;
    logic [NB*DW-1:0] wd;
    for (int k = 0; k < NB; k++) begin
      ra[k*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 1) wa[k*AW +: AW] = ra[k*AW +: AW];
      else wa[k*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
      wd[k*DW +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
    end
    apply_stimulus(1'($urandom_range(0, 1)), ra, NB'($urandom_range(0, (1 << NB) - 1)),
                   wa, wd, clr);
  endtask

  // Follow a clear sweep while hammering it with ignored traffic. restart_at
  // pulses clr_req on that busy cycle; abort_at asserts reset on that cycle.
  task automatic run_sweep(input string name, input int restart_at, input int abort_at);
    int n = 0;
    int guard = 0;
    int exp_len;
    m_ready = 1'b0;
    while (!busy && guard < 20) begin
      idle_cycle();
      guard++;
    end
    if (!busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_start: busy never rose within %0d cycles", name, guard);
      return;
    end
    while (busy && n < 100) begin
      if (n == abort_at) begin
        reset = 1'b0;
        #1;
        check_output({name, "_abort_busy"}, 32'(busy), 32'd0);
        check_output({name, "_abort_ready"}, 32'(ready), 32'd0);
        check_output({name, "_abort_rd_valid"}, 32'(rd_valid), 32'd0);
        check_output({name, "_abort_rd_data"}, 32'(rd_data), 32'd0);
        return;
      end
      check_output({name, "_ready_low"}, 32'(ready), 32'd0);
      if (n >= 1) check_output({name, "_rd_valid_low"}, 32'(rd_valid), 32'd0);
      random_cycle(n == restart_at);
      n++;
    end
    exp_len = (restart_at >= 0) ? (restart_at + 1 + DEPTH) : DEPTH;
    check_output({name, "_busy_len"}, 32'(n), 32'(exp_len));
    check_output({name, "_ready_after"}, 32'(ready), 32'd1);
    for (int k = 0; k < NB; k++)
      for (int a = 0; a < DEPTH; a++) ref_mem[k][a] = '0;
    m_ready = 1'b1;
  endtask

  // Read the same address on every lane for every address.
  task automatic read_all();
    logic [NB*AW-1:0] ra;
    for (int a = 0; a < DEPTH; a++) begin
      for (int k = 0; k < NB; k++) ra[k*AW +: AW] = AW'(a);
      apply_stimulus(1'b1, ra, '0, '0, '0, 1'b0);
    end
  endtask

  initial begin
    logic [NB*AW-1:0] ra;
    logic [NB*AW-1:0] wa;
    logic [NB*DW-1:0] wd;

    // Reset values while reset is held low.
    #2;
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_ready", 32'(ready), 32'd0);
    check_output("reset_rd_valid", 32'(rd_valid), 32'd0);
    check_output("reset_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Test 1: automatic sweep after reset, then every address reads zero.
    run_sweep("init_sweep", -1, -1);
    read_all();
    apply_stimulus(1'b1, '0, '0, '0, '0, 1'b0);
    check_output("rd_latency", 32'(rd_valid), 32'd1);
    idle_cycle();
    check_output("rd_valid_drop", 32'(rd_valid), 32'd0);
    check_output("rd_data_hold", 32'(rd_data), 32'(last_exp));

    // Test 2: lane 2 write then read back; other lanes read elsewhere.
    wa = '0; wa[2*AW +: AW] = AW'(5);
    wd = '0; wd[2*DW +: DW] = DW'(5'h13);
    apply_stimulus(1'b0, '0, 4'b0100, wa, wd, 1'b0);
    ra = '0; ra[2*AW +: AW] = AW'(5); ra[0 +: AW] = AW'(9); ra[3*AW +: AW] = AW'(2);
    apply_stimulus(1'b1, ra, '0, '0, '0, 1'b0);

    // Test 3: lane 1 same-cycle read/write collision, then a follow-up read.
    wa = '0; wa[1*AW +: AW] = AW'(3);
    wd = '0; wd[1*DW +: DW] = DW'(5'h13);
    apply_stimulus(1'b0, '0, 4'b0010, wa, wd, 1'b0);
    wd[1*DW +: DW] = DW'(5'h0A);
    ra = '0; ra[1*AW +: AW] = AW'(3);
    apply_stimulus(1'b1, ra, 4'b0010, wa, wd, 1'b0);
    apply_stimulus(1'b1, ra, '0, '0, '0, 1'b0);
    idle_cycle();

    // Random traffic in READY.
    for (int i = 0; i < 300; i++) random_cycle(1'b0);

    // Test 4: clear request with all-lane writes that must be dropped.
    ra = '0; ra[2*AW +: AW] = AW'(5); ra[1*AW +: AW] = AW'(3);
    for (int k = 0; k < NB; k++) wa[k*AW +: AW] = AW'(k + 1);
    wd = {NB{5'h1F}};
    apply_stimulus(1'b1, ra, 4'hF, wa, wd, 1'b1);
    run_sweep("clr_sweep", -1, -1);
    read_all();

    // Test 5: reset mid-sweep, hold, release, full sweep again.
    for (int i = 0; i < 50; i++) random_cycle(1'b0);
    apply_stimulus(1'b0, '0, '0, '0, '0, 1'b1);
    run_sweep("abort_sweep", -1, 7);
    m_ready = 1'b0;
    idle_cycle();
    idle_cycle();
    check_output("held_reset_busy", 32'(busy), 32'd0);
    check_output("held_reset_ready", 32'(ready), 32'd0);
    reset = 1'b1;
    run_sweep("rerun_sweep", -1, -1);
    read_all();

    // Test 6: clear request on busy cycle index 9 restarts the sweep.
    for (int i = 0; i < 50; i++) random_cycle(1'b0);
    apply_stimulus(1'b0, '0, '0, '0, '0, 1'b1);
    run_sweep("restart_sweep", 9, -1);
    for (int i = 0; i < 100; i++) random_cycle(1'b0);

    // Drain: every issued read must have been answered.
    idle_cycle();
    idle_cycle();
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
